hello_char_sequencer: RTL and testbench



---
 rtl/hello_char_sequencer_if.sv | 7 +
 rtl/hello_char_sequencer.sv | 121 ++++++++++++
 tb/tb_hello_char_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hello_char_sequencer_if.sv
// Character output bus of hello_char_sequencer: the generator drives io_out, consumers read it.
interface hello_char_sequencer_if;
    logic [7:0] io_out;

    modport master (output io_out);
    modport slave  (input  io_out);
endinterface

// File: rtl/hello_char_sequencer.sv
// Free-running "Hello" generator with per-character hold and an inter-message 0x00 gap.
// Build option: define HELLO_CRLF_EN to append CR/LF to the message (7 characters instead of 5).
module hello_char_sequencer #(
    parameter int CHAR_HOLD  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clock,
    input  logic                   io_rst,
    hello_char_sequencer_if.master bus
);

`ifdef HELLO_CRLF_EN
    localparam int unsigned N = 7;
`else
    localparam int unsigned N = 5;
`endif

    localparam int HW       = $clog2(CHAR_HOLD + 1);
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int HOLD_LAST = (CHAR_HOLD > 0) ? CHAR_HOLD - 1 : 0;

    if (CHAR_HOLD < 1) begin : g_bad_hold
        $error("hello_char_sequencer: CHAR_HOLD must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_SEND  = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q,   idx_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic [GW-1:0] gap_q,   gap_d;
    logic [7:0]    out_q,   out_d;

    function automatic logic [7:0] rom_byte(input logic [2:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            3'd0: b = 8'h48;
            3'd1: b = 8'h65;
            3'd2: b = 8'h6C;
            3'd3: b = 8'h6C;
            3'd4: b = 8'h6F;
`ifdef HELLO_CRLF_EN
            3'd5: b = 8'h0D;
            3'd6: b = 8'h0A;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        case (state_q)
            ST_SEND: begin
                // Out-of-range index/hold (e.g. upset) restarts the message at 'H'.
                if ((32'(idx_q) >= N) || (32'(hold_q) >= CHAR_HOLD)) begin
                    idx_d  = '0;
                    hold_d = '0;
                end else if (hold_q == HW'(HOLD_LAST)) begin
                    hold_d = '0;
                    if (32'(idx_q) == N - 1) begin
                        idx_d = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        idx_d = 3'(idx_q + 3'd1);
                    end
                end else begin
                    hold_d = HW'(hold_q + HW'(1));
                end
            end
            ST_GAP: begin
                if ((gap_q == GW'(GAP_LAST)) || (32'(gap_q) > GAP_LAST)) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    hold_d  = '0;
                    gap_d   = '0;
                end else begin
                    gap_d = GW'(gap_q + GW'(1));
                end
            end
            default: begin
                state_d = ST_SEND;
                idx_d   = '0;
                hold_d  = '0;
                gap_d   = '0;
            end
        endcase
        out_d = (state_d == ST_SEND) ? rom_byte(idx_d) : 8'h00;
    end

    always_ff @(posedge clock or negedge io_rst) begin
        if (!io_rst) begin
            state_q <= ST_RESET;
            idx_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
        end
    end

    assign bus.io_out = out_q;

endmodule

// File: tb/tb_hello_char_sequencer.sv
// Directed bench: three parameterisations share clock and reset; each output is checked against hand-written sequences.
module tb_hello_char_sequencer;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    hello_char_sequencer_if if_a ();
    hello_char_sequencer_if if_b ();
    hello_char_sequencer_if if_c ();

    hello_char_sequencer #(.CHAR_HOLD(1), .GAP_CYCLES(0)) dut_a (.clock(clk), .io_rst(rst_n), .bus(if_a));
    hello_char_sequencer #(.CHAR_HOLD(3), .GAP_CYCLES(0)) dut_b (.clock(clk), .io_rst(rst_n), .bus(if_b));
    hello_char_sequencer #(.CHAR_HOLD(1), .GAP_CYCLES(2)) dut_c (.clock(clk), .io_rst(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HELLO_CRLF_EN
    logic [7:0] exp_a [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A, 8'h48,
                               8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A, 8'h48, 8'h65};
    logic [7:0] exp_b [16] = '{8'h48, 8'h48, 8'h48, 8'h65, 8'h65, 8'h65, 8'h6C, 8'h6C,
                               8'h6C, 8'h6C, 8'h6C, 8'h6C, 8'h6F, 8'h6F, 8'h6F, 8'h0D};
    logic [7:0] exp_c [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A, 8'h00,
                               8'h00, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
`else
    logic [7:0] exp_a [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h48, 8'h65, 8'h6C,
                               8'h6C, 8'h6F, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h48};
    logic [7:0] exp_b [16] = '{8'h48, 8'h48, 8'h48, 8'h65, 8'h65, 8'h65, 8'h6C, 8'h6C,
                               8'h6C, 8'h6C, 8'h6C, 8'h6C, 8'h6F, 8'h6F, 8'h6F, 8'h48};
    logic [7:0] exp_c [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h00, 8'h00, 8'h48,
                               8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h00, 8'h00, 8'h48, 8'h65};
`endif

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic legal(input logic [7:0] b);
        logic ok;
        ok = (b == 8'h00) || (b == 8'h48) || (b == 8'h65) || (b == 8'h6C) || (b == 8'h6F);
`ifdef HELLO_CRLF_EN
        ok = ok || (b == 8'h0D) || (b == 8'h0A);
`endif
        return ok;
    endfunction

    initial begin
        logic found;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;

        // Held reset: outputs stay 0x00 across several edges
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_hold_a[%0d]", i), if_a.io_out, 8'h00);
            chk($sformatf("rst_hold_b[%0d]", i), if_b.io_out, 8'h00);
            chk($sformatf("rst_hold_c[%0d]", i), if_c.io_out, 8'h00);
        end

        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("seq_a[%0d]", k), if_a.io_out, exp_a[k]);
            chk($sformatf("seq_b[%0d]", k), if_b.io_out, exp_b[k]);
            chk($sformatf("seq_c[%0d]", k), if_c.io_out, exp_c[k]);
        end

        // Mid-message reset while dut_a shows 'l'
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (if_a.io_out === 8'h6C) found = 1'b1;
        end
        chk("wait_for_l", {7'd0, found}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("async_clr_a", if_a.io_out, 8'h00);
        chk("async_clr_b", if_b.io_out, 8'h00);
        chk("async_clr_c", if_c.io_out, 8'h00);
        @(negedge clk);
        chk("rst_after_edge_a", if_a.io_out, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_a", if_a.io_out, 8'h48);
        chk("restart_b", if_b.io_out, 8'h48);
        chk("restart_c", if_c.io_out, 8'h48);
        @(negedge clk);
        chk("restart2_a", if_a.io_out, 8'h65);
        chk("restart2_b", if_b.io_out, 8'h48);

        // Random reset toggling, changes kept off the clock edges
        #2;
        for (int i = 0; i < 10; i++) begin
            rst_n = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("noX_a[%0d]", i), {7'd0, ^if_a.io_out === 1'bx}, 8'h00);
            chk($sformatf("noX_c[%0d]", i), {7'd0, ^if_c.io_out === 1'bx}, 8'h00);
            if (!rst_n) begin
                chk($sformatf("rnd_rst_a[%0d]", i), if_a.io_out, 8'h00);
                chk($sformatf("rnd_rst_b[%0d]", i), if_b.io_out, 8'h00);
            end else begin
                chk($sformatf("rnd_legal_a[%0d]", i), {7'd0, legal(if_a.io_out)}, 8'h01);
                chk($sformatf("rnd_legal_b[%0d]", i), {7'd0, legal(if_b.io_out)}, 8'h01);
                chk($sformatf("rnd_legal_c[%0d]", i), {7'd0, legal(if_c.io_out)}, 8'h01);
            end
            #4;
        end

        rst_n = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
